// File: rtl/imem_fetch_port.sv
// rtl/imem_fetch_port.sv - instruction memory with registered fetch port, run/program FSM and load port
// Optional IMEM_FETCH_STATS_EN adds fetch_cnt/fault_cnt statistics outputs.
module imem_fetch_port #(
  parameter int ADDR_W = 32,
  parameter int INS_W = 32,
  parameter int DEPTH = 64,
  parameter logic [INS_W-1:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fetch_req,
  input  logic [ADDR_W-1:0]         fetch_addr,
  output logic                      fetch_ready,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [INS_W-1:0]          instruction,
  output logic                      fetch_fault,
  input  logic                      prog_req,
  output logic                      prog_mode,
  input  logic                      load_we,
  input  logic [INS_W-1:0]          load_data,
  output logic [$clog2(DEPTH):0]    load_ptr,
  output logic                      load_ovf
`ifdef IMEM_FETCH_STATS_EN
  ,
  output logic [31:0]               fetch_cnt,
  output logic [15:0]               fault_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH * 4);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_PROG} state_t;

  state_t state, state_nxt;
  logic [INS_W-1:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic misaligned, out_of_range, fault_c, accept, prog_enter, load_full, load_wr;

  assign idx          = fetch_addr[AW+1:2];
  assign misaligned   = (fetch_addr[1:0] != 2'b00);
  // Full-width compare so high addresses never alias back into the array.
  assign out_of_range = ({1'b0, fetch_addr} >= LIMIT);
  assign fault_c      = misaligned || out_of_range;
  assign accept       = fetch_req && fetch_ready;
  assign prog_enter   = (state == S_DRAIN) && (state_nxt == S_PROG);
  assign load_full    = (load_ptr == PW'(DEPTH));
  assign load_wr      = (state == S_PROG) && load_we && !load_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (prog_req) state_nxt = S_DRAIN;
      // Abort back to RUN takes priority over completing the drain.
      S_DRAIN: if (!prog_req) state_nxt = S_RUN;
               else if (!instr_valid || instr_ready) state_nxt = S_PROG;
      S_PROG:  if (!prog_req) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    prog_mode   = (state == S_PROG);
    fetch_ready = (state == S_RUN) && !prog_req && (!instr_valid || instr_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instruction <= '0;
      fetch_fault <= 1'b0;
    end else if (accept) begin
      instr_valid <= 1'b1;
      fetch_fault <= fault_c;
      instruction <= fault_c ? NOP_WORD : mem[idx];
    end else if (instr_ready) begin
      instr_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load_wr) mem[load_ptr[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_ptr <= '0;
      load_ovf <= 1'b0;
    end else if (prog_enter) begin
      load_ptr <= '0;
      load_ovf <= 1'b0;
    end else if ((state == S_PROG) && load_we) begin
      if (load_full) load_ovf <= 1'b1;
      else           load_ptr <= load_ptr + 1'b1;
    end
  end

`ifdef IMEM_FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      fault_cnt <= '0;
    end else if (prog_enter) begin
      fetch_cnt <= '0;
      fault_cnt <= '0;
    end else if (accept) begin
      if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + 1'b1;
      if (fault_c && (fault_cnt != '1)) fault_cnt <= fault_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_fetch_port.sv
// tb/tb_imem_fetch_port.sv - randomized self-checking bench for imem_fetch_port against a behavioural model
module tb_imem_fetch_port;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n;
  logic        fetch_req, fetch_ready, instr_valid, instr_ready, fetch_fault;
  logic [31:0] fetch_addr, instruction, load_data;
  logic        prog_req, prog_mode, load_we, load_ovf;
  logic [6:0]  load_ptr;
`ifdef IMEM_FETCH_STATS_EN
  logic [31:0] fetch_cnt;
  logic [15:0] fault_cnt;
`endif

  imem_fetch_port dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .fetch_fault(fetch_fault),
    .prog_req(prog_req), .prog_mode(prog_mode),
    .load_we(load_we), .load_data(load_data),
    .load_ptr(load_ptr), .load_ovf(load_ovf)
`ifdef IMEM_FETCH_STATS_EN
    , .fetch_cnt(fetch_cnt), .fault_cnt(fault_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: mode 0=running, 1=draining, 2=programming.
  int          m_mode, m_ptr, m_fcnt, m_flcnt;
  bit          m_valid, m_fault, m_ovf, m_iknown;
  logic [31:0] m_instr;
  logic [31:0] m_mem [64];
  bit          m_known [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    fetch_req = 0; instr_ready = 0; prog_req = 0; load_we = 0;
    rst_n = 0;
    #1;
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instruction, 0);
    check("rst_ptr", load_ptr, 0);
    check("rst_mode", prog_mode, 0);
    m_mode = 0; m_valid = 0; m_fault = 0; m_instr = 0; m_iknown = 1;
    m_ptr = 0; m_ovf = 0; m_fcnt = 0; m_flcnt = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic step(input bit req, input logic [31:0] addr, input bit rdy,
                      input bit preq, input bit we, input logic [31:0] data);
    bit exp_ready, acc, flt, old_valid;
    int old_mode;
    @(negedge clk);
    fetch_req = req; fetch_addr = addr; instr_ready = rdy;
    prog_req = preq; load_we = we; load_data = data;
    #1;
    exp_ready = (m_mode == 0) && !preq && (!m_valid || rdy);
    check("fetch_ready", fetch_ready, exp_ready);
    check("prog_mode", prog_mode, m_mode == 2);
    check("instr_valid", instr_valid, m_valid);
    check("fetch_fault", fetch_fault, m_fault);
    if (m_iknown) check("instruction", instruction, m_instr);
    check("load_ptr", load_ptr, m_ptr);
    check("load_ovf", load_ovf, m_ovf);
`ifdef IMEM_FETCH_STATS_EN
    check("fetch_cnt", fetch_cnt, m_fcnt);
    check("fault_cnt", fault_cnt, m_flcnt);
`endif
    old_mode = m_mode; old_valid = m_valid;
    acc = req && exp_ready;
    if (acc) begin
      flt = (addr % 4 != 0) || (addr >= 32'd256);
      m_valid = 1; m_fault = flt;
      if (flt) begin
        m_instr = NOP; m_iknown = 1;
      end else begin
        m_instr = m_mem[addr / 4]; m_iknown = m_known[addr / 4];
      end
      if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
      if (flt && m_flcnt != 16'hFFFF) m_flcnt++;
    end else if (rdy) begin
      m_valid = 0;
    end
    if (old_mode == 2 && we) begin
      if (m_ptr < 64) begin
        m_mem[m_ptr] = data; m_known[m_ptr] = 1; m_ptr++;
      end else begin
        m_ovf = 1;
      end
    end
    if (old_mode == 0 && preq) m_mode = 1;
    else if (old_mode == 1 && !preq) m_mode = 0;
    else if (old_mode == 1 && (!old_valid || rdy)) begin
      m_mode = 2; m_ptr = 0; m_ovf = 0; m_fcnt = 0; m_flcnt = 0;
    end else if (old_mode == 2 && !preq) m_mode = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 32'($urandom_range(0, 63)) << 2;
      3:       return 32'($urandom_range(0, 255));
      4:       return 32'hFC + 32'($urandom_range(0, 2)) * 4;
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] prog4 [4] = '{32'h00200093, 32'h00100113, 32'h00300193, 32'h00300213};
  logic [31:0] first_word;
  bit r_preq;

  initial begin
    rst_n = 0; fetch_req = 0; fetch_addr = 0; instr_ready = 0;
    prog_req = 0; load_we = 0; load_data = 0;
    for (int i = 0; i < 64; i++) m_known[i] = 0;
    do_reset();

    // Enter PROG, load four words, return to RUN.
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 1, 1, prog4[i]);
      if (i == 0) check("prog_mode_2cyc", prog_mode, 1);
    end
    step(0, 0, 1, 0, 0, 0);
    check("ptr_after4", load_ptr, 4);
    check("ovf_after4", load_ovf, 0);

    // Back-to-back fetches, then faults and range boundary.
    for (int i = 0; i < 4; i++) step(1, 32'(i * 4), 1, 0, 0, 0);
    step(1, 32'h6, 1, 0, 0, 0);
    check("word_0xC", instruction, 32'h00300213);
    step(1, 32'h100, 1, 0, 0, 0);
    check("fault_0x6", fetch_fault, 1);
    check("nop_0x6", instruction, NOP);
    step(1, 32'hFC, 1, 0, 0, 0);
    check("fault_0x100", fetch_fault, 1);
    step(0, 0, 1, 0, 0, 0);
    check("nofault_0xFC", fetch_fault, 0);

    // Backpressure: 0x4 held while 0x8 waits.
    step(1, 32'h4, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h8, 0, 0, 0, 0);
      check("stall_instr", instruction, 32'h00100113);
      check("stall_ready", fetch_ready, 0);
    end
    step(1, 32'h8, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("after_stall", instruction, 32'h00300193);

    // Drain waits for the handshake, then overflow the loader.
    step(1, 32'h0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    check("drain_hold", prog_mode, 0);
    step(0, 0, 1, 1, 0, 0);
    first_word = $urandom;
    for (int i = 0; i < 65; i++) step(0, 0, 1, 1, 1, (i == 0) ? first_word : $urandom);
    step(0, 0, 1, 0, 0, 0);
    check("ptr_full", load_ptr, 64);
    check("ovf_set", load_ovf, 1);
    step(1, 32'h0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    check("mem0_kept", instruction, first_word);

    // Reset in the middle of a load, then fetch the new words.
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 1, 1, 1, 32'hAAAA_0001);
    step(0, 0, 1, 1, 1, 32'hAAAA_0002);
    step(1, 32'h0, 0, 1, 0, 0);
    do_reset();
    step(1, 32'h0, 1, 0, 0, 0);
    step(1, 32'h4, 1, 0, 0, 0);
    check("reset_w0", instruction, 32'hAAAA_0001);
    step(0, 0, 1, 0, 0, 0);
    check("reset_w1", instruction, 32'hAAAA_0002);
`ifdef IMEM_FETCH_STATS_EN
    check("stats_fetch2", fetch_cnt, 2);
    check("stats_fault0", fault_cnt, 0);
`endif

    // Randomized traffic against the model.
    r_preq = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) r_preq = !r_preq;
      step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0,
           r_preq, $urandom_range(0, 1) == 1, $urandom);
      if ($urandom_range(0, 999) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
